// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } arb_gnt_t;

   // Counter width able to hold 0..n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n > 0) begin
         return $clog2(n + 1);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus between the arbiter (master) and the memory (slave).
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_rdy;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_rdy
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_rdy
   );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Watchdog counter: cleared at the start of an access, counts enabled cycles,
// flags the last permitted cycle. TIMEOUT = 0 disables it.
module mem_arb_wdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic [CW-1:0] wd_cnt_r;

   // Cycle counter for the current access, saturating so it can never wrap.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         wd_cnt_r <= {CW{1'b0}};
      end else if (en && (wd_cnt_r != CMAX)) begin
         wd_cnt_r <= wd_cnt_r + CW'(1);
      end
   end

   // Expiry decode: true during the final cycle the memory is allowed.
   always_comb begin
      if ((TIMEOUT > 0) && (wd_cnt_r == LAST)) begin
         expired = 1'b1;
      end else begin
         expired = 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and load/store
// requesters, serialising accesses and producing pipeline stall signals.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               if_req,
   input  logic [AW-1:0]      if_addr,
   output logic [DW-1:0]      if_rdata,
   output logic               if_done,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [AW-1:0]      d_addr,
   input  logic [DW-1:0]      d_wdata,
   output logic [DW-1:0]      d_rdata,
   output logic               d_done,
   mem_port_arbiter_if.master mem,
   output logic               StallF,
   output logic               StallM,
   output logic               bus_err
);

   localparam int            SW         = cnt_width(STARVE_LIM);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

   arb_state_t    state_r, state_s;
   arb_gnt_t      gnt_r, gnt_sel_s;
   logic [SW-1:0] starve_cnt_r;
   logic          req_any_s, promote_s, expired_s;
   logic          grant_s, busy_s, complete_s, err_s;
   logic          mem_req_r, mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r, if_rdata_r, d_rdata_r;
   logic          if_done_r, d_done_r, bus_err_r;

   // Grant selection: data wins unless fetch has been passed over too often.
   always_comb begin
      req_any_s = if_req | d_req;
      promote_s = (STARVE_LIM > 0) && if_req && (starve_cnt_r == STARVE_MAX);
      if (d_req && !promote_s) begin
         gnt_sel_s = GNT_D;
      end else begin
         gnt_sel_s = GNT_IF;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_any_s) begin
               state_s = BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (mem.mem_rdy || expired_s) begin
               state_s = DONE;
            end else begin
               state_s = BUSY;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // FSM output decode; memory readiness only matters while BUSY.
   always_comb begin
      grant_s    = 1'b0;
      busy_s     = 1'b0;
      complete_s = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         IDLE: grant_s = req_any_s;
         BUSY: begin
            busy_s     = 1'b1;
            complete_s = mem.mem_rdy | expired_s;
            err_s      = expired_s & ~mem.mem_rdy;
         end
         DONE: begin
            grant_s = 1'b0;
         end
         default: begin
            grant_s = 1'b0;
         end
      endcase
   end

   mem_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (grant_s),
      .en      (busy_s),
      .expired (expired_s)
   );

   // Starvation counter: data grants taken while fetch was waiting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_cnt_r <= {SW{1'b0}};
      end else if (grant_s) begin
         if (gnt_sel_s == GNT_IF) begin
            starve_cnt_r <= {SW{1'b0}};
         end else if (if_req && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
         end
      end else if ((state_r == IDLE) && !if_req) begin
         starve_cnt_r <= {SW{1'b0}};
      end
   end

   // Memory bus and completion registers; fields latched at grant stay stable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gnt_r       <= GNT_IF;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
         if_rdata_r  <= {DW{1'b0}};
         d_rdata_r   <= {DW{1'b0}};
         if_done_r   <= 1'b0;
         d_done_r    <= 1'b0;
         bus_err_r   <= 1'b0;
      end else begin
         if (grant_s) begin
            gnt_r     <= gnt_sel_s;
            mem_req_r <= 1'b1;
            if (gnt_sel_s == GNT_D) begin
               mem_we_r    <= d_we;
               mem_addr_r  <= d_addr;
               mem_wdata_r <= d_wdata;
            end else begin
               mem_we_r    <= 1'b0;
               mem_addr_r  <= if_addr;
               mem_wdata_r <= {DW{1'b0}};
            end
         end else if (complete_s) begin
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
         end
         if (complete_s && (gnt_r == GNT_IF)) begin
            if_rdata_r <= err_s ? {DW{1'b0}} : mem.mem_rdata;
         end
         if (complete_s && (gnt_r == GNT_D)) begin
            if (err_s) begin
               d_rdata_r <= {DW{1'b0}};
            end else if (!mem_we_r) begin
               d_rdata_r <= mem.mem_rdata;
            end
         end
         if_done_r <= complete_s && (gnt_r == GNT_IF);
         d_done_r  <= complete_s && (gnt_r == GNT_D);
         bus_err_r <= err_s;
      end
   end

   assign mem.mem_req   = mem_req_r;
   assign mem.mem_we    = mem_we_r;
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_wdata = mem_wdata_r;
   assign if_rdata      = if_rdata_r;
   assign d_rdata       = d_rdata_r;
   assign if_done       = if_done_r;
   assign d_done        = d_done_r;
   assign bus_err       = bus_err_r;
   assign StallF        = reset & if_req & ~if_done_r;
   assign StallM        = reset & d_req & ~d_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory responder model,
// in-order completion scoreboard and one task per scenario.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata;
   logic        if_done, d_done, StallF, StallM, bus_err;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(
      .AW(32), .DW(32), .STARVE_LIM(4), .TIMEOUT(16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_done  (if_done),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_done   (d_done),
      .mem      (bus.master),
      .StallF   (StallF),
      .StallM   (StallM),
      .bus_err  (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          fetch;
      logic [31:0] rdata;
      bit          err;
      bit          chk_data;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0010) mem_model = 32'hDEAD_BEEF;
      else mem_model = (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // Memory responder: mem_rdy after rdy_delay waiting cycles (-1 = never).
   int rdy_delay = 0;
   bit manual_mem = 1'b0;
   bit manual_rdy = 1'b0;
   int wait_cnt = 0;
   bit pulsed = 1'b0;
   always @(negedge clk) begin
      bus.mem_rdy = 1'b0;
      if (manual_mem) begin
         bus.mem_rdy = manual_rdy;
         bus.mem_rdata = 32'hBAD0_BAD0;
         wait_cnt = 0;
         pulsed = 1'b0;
      end else if (!bus.mem_req) begin
         wait_cnt = 0;
         pulsed = 1'b0;
      end else if (!pulsed && rdy_delay >= 0) begin
         if (wait_cnt == rdy_delay) begin
            bus.mem_rdy = 1'b1;
            bus.mem_rdata = mem_model(bus.mem_addr);
            pulsed = 1'b1;
         end else begin
            wait_cnt++;
         end
      end
   end

   // Completion monitor: every done pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (reset && (if_done || d_done)) begin
         checks++;
         if (if_done && d_done) begin
            errors++;
            $display("FAIL dual_done: if_done=1 d_done=1, required at most one");
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: if_done=%0b d_done=%0b, required no completion", if_done, d_done);
         end else begin
            mon_e = sb.pop_front();
            if (if_done !== mon_e.fetch || bus_err !== mon_e.err ||
                (mon_e.chk_data && ((mon_e.fetch ? if_rdata : d_rdata) !== mon_e.rdata))) begin
               errors++;
               $display("FAIL scoreboard: got fetch=%0b err=%0b rdata=%h, required fetch=%0b err=%0b rdata=%h",
                        if_done, bus_err, (if_done ? if_rdata : d_rdata), mon_e.fetch, mon_e.err, mon_e.rdata);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; if_req = 1'b1; d_req = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({StallF, StallM, bus.mem_req, if_done, d_done, bus_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {StallF, StallM, bus.mem_req, if_done, d_done, bus_err});
      end
      checks++;
      if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: if_rdata=%h d_rdata=%h mem_addr=%h mem_we=%b, required all 0",
                  if_rdata, d_rdata, bus.mem_addr, bus.mem_we);
      end
      if_req = 1'b0; d_req = 1'b0; reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lone_fetch();
      @(negedge clk);
      if_addr = 32'h10; if_req = 1'b1;
      sb.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1});
      #1;
      checks++;
      if (StallF !== 1'b1 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_c0: StallF=%b mem_req=%b, required 1 0", StallF, bus.mem_req);
      end
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 || StallF !== 1'b1 || if_done !== 1'b0) begin
         errors++;
         $display("FAIL fetch_c1: mem_req=%b addr=%h we=%b StallF=%b if_done=%b, required 1 00000010 0 1 0",
                  bus.mem_req, bus.mem_addr, bus.mem_we, StallF, if_done);
      end
      @(negedge clk);
      checks++;
      if (if_done !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || StallF !== 1'b0) begin
         errors++;
         $display("FAIL fetch_c2: if_done=%b if_rdata=%h StallF=%b, required 1 deadbeef 0", if_done, if_rdata, StallF);
      end
      if_req = 1'b0;
      @(negedge clk);
      checks++;
      if (if_done !== 1'b0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL fetch_c3: if_done=%b mem_req=%b, required 0 0", if_done, bus.mem_req);
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      if_addr = 32'h44; if_req = 1'b1;
      d_addr = 32'h20; d_wdata = 32'h55; d_we = 1'b1; d_req = 1'b1;
      sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
      sb.push_back('{1'b1, mem_model(32'h44), 1'b0, 1'b1});
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h55) begin
         errors++;
         $display("FAIL coll_store: req=%b we=%b addr=%h wdata=%h, required 1 1 00000020 00000055",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      checks++;
      if (d_done !== 1'b1 || if_done !== 1'b0 || StallM !== 1'b0 || StallF !== 1'b1) begin
         errors++;
         $display("FAIL coll_ddone: d_done=%b if_done=%b StallM=%b StallF=%b, required 1 0 0 1",
                  d_done, if_done, StallM, StallF);
      end
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h44) begin
         errors++;
         $display("FAIL coll_fetch: req=%b we=%b addr=%h, required 1 0 00000044", bus.mem_req, bus.mem_we, bus.mem_addr);
      end
      @(negedge clk);
      checks++;
      if (if_done !== 1'b1) begin
         errors++;
         $display("FAIL coll_ifdone: if_done=%b, required 1", if_done);
      end
      if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_starvation();
      int nd = 0;
      int d_since = 0;
      int round = 0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            sb.push_back('{1'b0, mem_model(32'h200 + 32'((r * 4 + k) * 4)), 1'b0, 1'b1});
         sb.push_back('{1'b1, mem_model(32'h100 + 32'(r * 4)), 1'b0, 1'b1});
      end
      @(negedge clk);
      if_addr = 32'h100; if_req = 1'b1;
      d_addr = 32'h200; d_we = 1'b0; d_req = 1'b1;
      for (int c = 0; c < 80 && round < 2; c++) begin
         @(negedge clk);
         if (d_done) begin
            nd++; d_since++;
            d_addr = 32'h200 + 32'(nd * 4);
         end
         if (if_done) begin
            checks++;
            if (d_since !== 4) begin
               errors++;
               $display("FAIL starve_round%0d: data grants before fetch=%0d, required 4", round, d_since);
            end
            d_since = 0; round++;
            if_addr = 32'h100 + 32'(round * 4);
         end
      end
      checks++;
      if (round !== 2) begin
         errors++;
         $display("FAIL starve_timeout: fetch grants=%0d, required 2", round);
      end
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int nd = 0;
      int last = 0;
      for (int k = 0; k < 3; k++) sb.push_back('{1'b1, mem_model(32'h600 + 32'(k * 4)), 1'b0, 1'b1});
      @(negedge clk);
      if_addr = 32'h600; if_req = 1'b1;
      for (int cyc = 1; cyc < 30 && nd < 3; cyc++) begin
         @(negedge clk);
         if (if_done) begin
            checks++;
            if (nd == 0 && cyc != 2) begin
               errors++;
               $display("FAIL b2b_first: done at cycle %0d, required 2", cyc);
            end else if (nd > 0 && cyc - last != 3) begin
               errors++;
               $display("FAIL b2b_spacing: spacing %0d, required 3", cyc - last);
            end
            last = cyc; nd++;
            if_addr = 32'h600 + 32'(nd * 4);
         end
      end
      checks++;
      if (nd !== 3) begin
         errors++;
         $display("FAIL b2b_count: fetch dones=%0d, required 3", nd);
      end
      if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int busy = 0;
      int early = 0;
      bit seen = 1'b0;
      @(negedge clk);
      rdy_delay = -1;
      d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
      sb.push_back('{1'b0, 32'h0, 1'b1, 1'b1});
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (d_done) begin
            seen = 1'b1;
            checks++;
            if (bus_err !== 1'b1 || d_rdata !== 32'h0) begin
               errors++;
               $display("FAIL timeout_done: bus_err=%b d_rdata=%h, required 1 00000000", bus_err, d_rdata);
            end
            break;
         end
         if (bus_err) early++;
         if (bus.mem_req) busy++;
      end
      checks++;
      if (!seen || busy !== 16 || early !== 0) begin
         errors++;
         $display("FAIL timeout_busy: seen=%0b busy=%0d early_err=%0d, required 1 16 0", seen, busy, early);
      end
      d_req = 1'b0; rdy_delay = 0;
      @(negedge clk);
      checks++;
      if (bus_err !== 1'b0 || d_done !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: bus_err=%b d_done=%b, required 0 0", bus_err, d_done);
      end
   endtask

   task automatic test_reset_mid_busy();
      int dn = 0;
      int rq = 0;
      @(negedge clk);
      manual_mem = 1'b1; manual_rdy = 1'b0;
      d_we = 1'b0; d_addr = 32'h400; d_req = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL rst_busy_pre: mem_req=%b, required 1", bus.mem_req);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, if_done, d_done, bus_err, StallF, StallM} !== 7'b0 ||
          if_rdata !== 32'h0 || d_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_busy_outs: ctrl=%b if_rdata=%h d_rdata=%h addr=%h wdata=%h, required all 0",
                  {bus.mem_req, bus.mem_we, if_done, d_done, bus_err, StallF, StallM},
                  if_rdata, d_rdata, bus.mem_addr, bus.mem_wdata);
      end
      reset = 1'b1; d_req = 1'b0; manual_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (if_done || d_done) dn++;
         if (bus.mem_req) rq++;
         if (c == 2) manual_rdy = 1'b0;
      end
      manual_mem = 1'b0;
      checks++;
      if (dn !== 0 || rq !== 0) begin
         errors++;
         $display("FAIL rst_busy_after: dones=%0d mem_req cycles=%0d, required 0 0", dn, rq);
      end
   endtask

   task automatic test_wait_states();
      int busy = 0;
      int unstable = 0;
      int dn = 0;
      @(negedge clk);
      rdy_delay = 7;
      d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
      sb.push_back('{1'b0, 32'h0, 1'b0, 1'b0});
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.mem_req) begin
            busy++;
            if (bus.mem_addr !== 32'h500 || bus.mem_wdata !== 32'hCAFE_F00D || bus.mem_we !== 1'b1) unstable++;
         end
         if (d_done) begin
            dn++;
            d_req = 1'b0; d_we = 1'b0;
         end
         if (c == 3) begin
            d_addr = 32'h5FC; d_wdata = 32'h1111_1111;
         end
      end
      rdy_delay = 0;
      checks++;
      if (unstable !== 0 || busy !== 8 || dn !== 1) begin
         errors++;
         $display("FAIL wait_states: unstable=%0d busy=%0d dones=%0d, required 0 8 1", unstable, busy, dn);
      end
   endtask

   initial begin
      reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      test_reset();
      test_lone_fetch();
      test_collision();
      test_starvation();
      test_back_to_back();
      test_timeout();
      test_reset_mid_busy();
      test_wait_states();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
